// File: rtl/regfile_slc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_slc_pkg
// Description : Shared typedefs and helpers for the slice-serial register
//               file: access size, extension mode, write-sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_slc_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } cs_size;

  typedef enum logic {
    EXT_Z = 1'b0,
    EXT_S = 1'b1
  } cs_ext;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    EXT  = 2'd2
  } wseq_state_e;

  // Number of meaningful bits carried by an access of the given size.
  function automatic int size_bits(input cs_size size, input int xlen);
    case (size)
      SIZE_B:  size_bits = 8;
      SIZE_H:  size_bits = 16;
      default: size_bits = xlen;
    endcase
  endfunction

  // Number of slices that must come from the data input for a given size.
  function automatic int data_slices(input cs_size size, input int slice_w,
                                     input int nslice);
    case (size)
      SIZE_B:  data_slices = 1;
      SIZE_H:  data_slices = (16 + slice_w - 1) / slice_w;
      default: data_slices = nslice;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wseq.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wseq
// Description : Write sequencer for the slice-serial register file. Accepts a
//               write request, steps through the data slices (stalling while
//               no slice is offered), then fills the remaining upper slices
//               with the extension value.
// Revision    : 1.0 - initial release
// Ports       : clk, rst (async, active-high)
//               wr_valid_i/wr_rd_i/wr_size_i/wr_ext_i : request
//               sdata_valid_i/sdata_i                  : slice data, LSB first
//               wr_ready_o/wr_busy_o/wr_done_o         : status
//               we_o/we_rd_o/we_slice_o/we_data_o      : slice write to storage
// ============================================================================
module regfile_wseq
  import regfile_slc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid_i,
  input  logic [4:0]           wr_rd_i,
  input  cs_size               wr_size_i,
  input  cs_ext                wr_ext_i,
  input  logic                 sdata_valid_i,
  input  logic [SLICE_W-1:0]   sdata_i,
  output logic                 wr_ready_o,
  output logic                 wr_busy_o,
  output logic                 wr_done_o,
  output logic                 we_o,
  output logic [4:0]           we_rd_o,
  output logic [((XLEN/SLICE_W) > 1 ? $clog2(XLEN/SLICE_W) : 1)-1:0] we_slice_o,
  output logic [SLICE_W-1:0]   we_data_o
);

  localparam int c_nslice = XLEN / SLICE_W;
  localparam int c_cnt_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;
  // Bit 15 of the register lands at this position of the last halfword slice.
  localparam int c_h_msb  = 15 % SLICE_W;

  wseq_state_e          r_state;
  wseq_state_e          w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [4:0]           r_rd;
  cs_size               r_size;
  cs_ext                r_ext;
  logic                 r_ext_bit;

  int                   w_nd;
  logic                 w_last_data;
  logic                 w_last_ext;
  logic                 w_sign;
  logic                 w_ext_bit;
  logic                 w_we;
  logic                 w_done;
  logic [SLICE_W-1:0]   w_data;

  always_comb begin
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_done      = 1'b0;
    w_nd        = data_slices(r_size, SLICE_W, c_nslice);
    w_last_data = (int'(r_cnt) == w_nd - 1);
    w_last_ext  = (int'(r_cnt) == c_nslice - 1);
    w_sign      = (r_size == SIZE_B) ? sdata_i[7] : sdata_i[c_h_msb];
    w_ext_bit   = (r_ext == EXT_S) && w_sign;
    w_data      = sdata_i;
    // Bits of this slice that lie above the access width take the extension.
    for (int j = 0; j < SLICE_W; j++) begin
      if (int'(r_cnt) * SLICE_W + j >= size_bits(r_size, XLEN)) begin
        w_data[j] = w_ext_bit;
      end
    end

    case (r_state)
      IDLE: begin
        if (wr_valid_i) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (sdata_valid_i) begin
          w_we = 1'b1;
          if (w_last_data) begin
            if (w_nd < c_nslice) begin
              w_state_nxt = EXT;
            end else begin
              w_state_nxt = IDLE;
              w_done      = 1'b1;
            end
          end
        end
      end
      EXT: begin
        w_we   = 1'b1;
        w_data = {SLICE_W{r_ext_bit}};
        if (w_last_ext) begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_rd      <= '0;
      r_size    <= SIZE_B;
      r_ext     <= EXT_Z;
      r_ext_bit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (wr_valid_i) begin
            r_rd   <= wr_rd_i;
            r_size <= wr_size_i;
            r_ext  <= wr_ext_i;
            r_cnt  <= '0;
          end
        end
        DATA: begin
          if (sdata_valid_i) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_last_data) begin
              r_ext_bit <= w_ext_bit;
            end
          end
        end
        EXT: begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign wr_ready_o = (r_state == IDLE);
  assign wr_busy_o  = !wr_ready_o;
  assign wr_done_o  = w_done;
  assign we_o       = w_we;
  assign we_rd_o    = r_rd;
  assign we_slice_o = r_cnt;
  assign we_data_o  = w_data;

endmodule
`default_nettype wire

// File: rtl/regfile_slc.sv
`default_nettype none
// ============================================================================
// Module      : regfile_slc
// Description : Register file written one SLICE_W-bit slice per cycle with
//               byte/halfword/word sizes and zero/sign extension; two
//               combinational read ports (full word and selected slice).
//               Optional macro REGFILE_BYPASS_EN forwards the slice being
//               written this cycle to the read ports.
// Revision    : 1.0 - initial release
// Ports       : clk, rst (async, active-high)
//               wr_valid_i, wr_ready_o, wr_rd_i, wr_size_i, wr_ext_i
//               sdata_valid_i, sdata_i, wr_busy_o, wr_done_o
//               rs1_i -> rs1_do (XLEN), rs2_i/rs2_slice_i -> rs2_do (SLICE_W)
// ============================================================================
module regfile_slc
  import regfile_slc_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SLICE_W = 16,
  parameter int NREG    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  input  logic [4:0]           wr_rd_i,
  input  cs_size               wr_size_i,
  input  cs_ext                wr_ext_i,
  input  logic                 sdata_valid_i,
  input  logic [SLICE_W-1:0]   sdata_i,
  output logic                 wr_busy_o,
  output logic                 wr_done_o,
  input  logic [4:0]           rs1_i,
  input  logic [4:0]           rs2_i,
  input  logic [((XLEN/SLICE_W) > 1 ? $clog2(XLEN/SLICE_W) : 1)-1:0] rs2_slice_i,
  output logic [XLEN-1:0]      rs1_do,
  output logic [SLICE_W-1:0]   rs2_do
);

  localparam int c_nslice = XLEN / SLICE_W;
  localparam int c_cnt_w  = (c_nslice > 1) ? $clog2(c_nslice) : 1;

  logic [XLEN-1:0]    r_regs [NREG];

  logic               w_we;
  logic [4:0]         w_we_rd;
  logic [c_cnt_w-1:0] w_we_slice;
  logic [SLICE_W-1:0] w_we_data;
  logic               w_store;
  logic [XLEN-1:0]    w_rs1_word;
  logic [XLEN-1:0]    w_rs2_word;

  regfile_wseq #(
    .XLEN    (XLEN),
    .SLICE_W (SLICE_W)
  ) u_wseq (
    .clk           (clk),
    .rst           (rst),
    .wr_valid_i    (wr_valid_i),
    .wr_rd_i       (wr_rd_i),
    .wr_size_i     (wr_size_i),
    .wr_ext_i      (wr_ext_i),
    .sdata_valid_i (sdata_valid_i),
    .sdata_i       (sdata_i),
    .wr_ready_o    (wr_ready_o),
    .wr_busy_o     (wr_busy_o),
    .wr_done_o     (wr_done_o),
    .we_o          (w_we),
    .we_rd_o       (w_we_rd),
    .we_slice_o    (w_we_slice),
    .we_data_o     (w_we_data)
  );

  // x0 transactions run the full sequence but never touch storage.
  assign w_store = w_we && (w_we_rd != 5'd0) && (int'(w_we_rd) < NREG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_store) begin
      for (int s = 0; s < c_nslice; s++) begin
        if (w_we_slice == c_cnt_w'(s)) begin
          r_regs[w_we_rd][s*SLICE_W +: SLICE_W] <= w_we_data;
        end
      end
    end
  end

  always_comb begin
    w_rs1_word = '0;
    w_rs2_word = '0;
    if ((rs1_i != 5'd0) && (int'(rs1_i) < NREG)) begin
      w_rs1_word = r_regs[rs1_i];
    end
    if ((rs2_i != 5'd0) && (int'(rs2_i) < NREG)) begin
      w_rs2_word = r_regs[rs2_i];
    end
`ifdef REGFILE_BYPASS_EN
    for (int s = 0; s < c_nslice; s++) begin
      if (w_store && (w_we_slice == c_cnt_w'(s))) begin
        if (rs1_i == w_we_rd) begin
          w_rs1_word[s*SLICE_W +: SLICE_W] = w_we_data;
        end
        if (rs2_i == w_we_rd) begin
          w_rs2_word[s*SLICE_W +: SLICE_W] = w_we_data;
        end
      end
    end
`endif
    rs1_do = w_rs1_word;
    rs2_do = '0;
    for (int s = 0; s < c_nslice; s++) begin
      if (rs2_slice_i == c_cnt_w'(s)) begin
        rs2_do = w_rs2_word[s*SLICE_W +: SLICE_W];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_slc.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_slc
// Description : Self-checking bench for regfile_slc (default parameters).
//               Stimulus pushes expected read values and expected wr_done_o
//               cycles into queues; a negedge monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_slc;
  import regfile_slc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [4:0]  wr_rd_i;
  cs_size      wr_size_i;
  cs_ext       wr_ext_i;
  logic        sdata_valid_i;
  logic [15:0] sdata_i;
  logic        wr_busy_o;
  logic        wr_done_o;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic [0:0]  rs2_slice_i;
  logic [31:0] rs1_do;
  logic [15:0] rs2_do;

  regfile_slc #(.XLEN(32), .SLICE_W(16), .NREG(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_valid_i    (wr_valid_i),
    .wr_ready_o    (wr_ready_o),
    .wr_rd_i       (wr_rd_i),
    .wr_size_i     (wr_size_i),
    .wr_ext_i      (wr_ext_i),
    .sdata_valid_i (sdata_valid_i),
    .sdata_i       (sdata_i),
    .wr_busy_o     (wr_busy_o),
    .wr_done_o     (wr_done_o),
    .rs1_i         (rs1_i),
    .rs2_i         (rs2_i),
    .rs2_slice_i   (rs2_slice_i),
    .rs1_do        (rs1_do),
    .rs2_do        (rs2_do)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] e1;
    logic [15:0] e2;
    logic        er;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      done_q[$];
  rd_exp_t e;
  int      exp_cyc;
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;
  logic    chk_req = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares whatever the DUT presents against the queued values.
  always @(negedge clk) begin
    if (chk_req) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_queue_empty: got strobe want queued entry");
      end else begin
        e = rd_q.pop_front();
        checks++;
        if (rs1_do !== e.e1) begin
          errors++;
          $display("FAIL %s rs1_do: got %h want %h", e.nm, rs1_do, e.e1);
        end
        checks++;
        if (rs2_do !== e.e2) begin
          errors++;
          $display("FAIL %s rs2_do: got %h want %h", e.nm, rs2_do, e.e2);
        end
        checks++;
        if (wr_ready_o !== e.er) begin
          errors++;
          $display("FAIL %s wr_ready_o: got %b want %b", e.nm, wr_ready_o, e.er);
        end
        checks++;
        if (wr_busy_o !== !e.er) begin
          errors++;
          $display("FAIL %s wr_busy_o: got %b want %b", e.nm, wr_busy_o, !e.er);
        end
      end
    end
    if (wr_done_o) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got pulse at cycle %0d want none", cyc);
      end else begin
        exp_cyc = done_q.pop_front();
        if (cyc != exp_cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d want %0d", cyc, exp_cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic check_rd(input string nm, input logic [4:0] a, input logic [4:0] b,
                          input logic sl, input logic [31:0] e1, input logic [15:0] e2,
                          input logic er);
    rs1_i       = a;
    rs2_i       = b;
    rs2_slice_i = sl;
    rd_q.push_back('{nm, e1, e2, er});
    chk_req = 1'b1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 16 && !wr_ready_o; k++) step();
    if (!wr_ready_o) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy want ready within 16 cycles");
    end
  endtask

  // One write transaction; lat = hand-computed cycles from request to done.
  task automatic do_write(input logic [4:0] rd, input cs_size sz, input cs_ext ex,
                          input logic [15:0] s0, input logic [15:0] s1, input int nsl,
                          input int nstall, input int lat, input logic junk);
    wr_valid_i = 1'b1;
    wr_rd_i    = rd;
    wr_size_i  = sz;
    wr_ext_i   = ex;
    done_q.push_back(cyc + lat);
    step();
    wr_valid_i = 1'b0;
    for (int i = 0; i < nstall; i++) begin
      sdata_valid_i = 1'b0;
      wr_valid_i    = 1'b1;     // must be ignored while busy
      wr_rd_i       = 5'd1;
      step();
    end
    wr_valid_i = 1'b0;
    for (int i = 0; i < nsl; i++) begin
      sdata_valid_i = 1'b1;
      sdata_i       = (i == 0) ? s0 : s1;
      step();
    end
    sdata_valid_i = junk;       // must be ignored in EXT and IDLE
    sdata_i       = 16'h5555;
    wait_idle();
    step();
    sdata_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wr_valid_i = 1'b0; wr_rd_i = 5'd0; wr_size_i = SIZE_B; wr_ext_i = EXT_Z;
    sdata_valid_i = 1'b0; sdata_i = 16'h0; rs1_i = 5'd0; rs2_i = 5'd0; rs2_slice_i = 1'b0;
    step(); step();
    check_rd("rst_hold", 5'd5, 5'd5, 1'b0, 32'h0, 16'h0, 1'b1); step();
    rst = 1'b0; step();
    for (int i = 0; i < 32; i++) begin
      check_rd("rst_reg", 5'(i), 5'(i), 1'(i & 1), 32'h0, 16'h0, 1'b1);
      step();
    end

    // Word write to x5, observing the second DATA cycle mid-transaction.
    wr_valid_i = 1'b1; wr_rd_i = 5'd5; wr_size_i = SIZE_W; wr_ext_i = EXT_Z;
    done_q.push_back(cyc + 2);
    step();
    wr_valid_i = 1'b0; sdata_valid_i = 1'b1; sdata_i = 16'h1234;
    step();
    sdata_i = 16'hABCD;
`ifdef REGFILE_BYPASS_EN
    check_rd("x5_mid", 5'd5, 5'd5, 1'b1, 32'hABCD1234, 16'hABCD, 1'b0);
`else
    check_rd("x5_mid", 5'd5, 5'd5, 1'b1, 32'h00001234, 16'h0000, 1'b0);
`endif
    step();
    sdata_valid_i = 1'b0;
    wait_idle();
    check_rd("x5_word", 5'd5, 5'd5, 1'b1, 32'hABCD1234, 16'hABCD, 1'b1); step();

    do_write(5'd7, SIZE_B, EXT_S, 16'h0080, 16'h0, 1, 0, 2, 1'b1);
    check_rd("x7_bs", 5'd7, 5'd7, 1'b0, 32'hFFFFFF80, 16'hFF80, 1'b1); step();

    do_write(5'd9, SIZE_H, EXT_Z, 16'h8001, 16'h0, 1, 2, 4, 1'b0);
    check_rd("x9_hz", 5'd9, 5'd1, 1'b0, 32'h00008001, 16'h0000, 1'b1); step();

    do_write(5'd10, SIZE_B, EXT_Z, 16'h12F0, 16'h0, 1, 0, 2, 1'b0);
    check_rd("x10_bz", 5'd10, 5'd10, 1'b0, 32'h000000F0, 16'h00F0, 1'b1); step();

    do_write(5'd11, SIZE_H, EXT_S, 16'h9234, 16'h0, 1, 0, 2, 1'b0);
    check_rd("x11_hs", 5'd11, 5'd11, 1'b1, 32'hFFFF9234, 16'hFFFF, 1'b1); step();

    do_write(5'd0, SIZE_W, EXT_Z, 16'hDEAD, 16'hBEEF, 2, 0, 2, 1'b0);
    check_rd("x0_word", 5'd0, 5'd0, 1'b1, 32'h0, 16'h0, 1'b1); step();
    check_rd("x5_keep", 5'd5, 5'd5, 1'b0, 32'hABCD1234, 16'h1234, 1'b1); step();

    // Reset in the middle of a word write to x3: aborted, no done pulse.
    wr_valid_i = 1'b1; wr_rd_i = 5'd3; wr_size_i = SIZE_W; wr_ext_i = EXT_Z;
    step();
    wr_valid_i = 1'b0; sdata_valid_i = 1'b1; sdata_i = 16'h1111;
    step();
    sdata_valid_i = 1'b0;
    check_rd("x3_part", 5'd3, 5'd3, 1'b0, 32'h00001111, 16'h1111, 1'b0);
    step();
    rst = 1'b1; sdata_valid_i = 1'b1; sdata_i = 16'h2222;
    check_rd("x3_rst", 5'd3, 5'd3, 1'b0, 32'h0, 16'h0, 1'b1);
    step(); step();
    rst = 1'b0;
    step();
    sdata_valid_i = 1'b0;
    check_rd("x3_after", 5'd3, 5'd3, 1'b1, 32'h0, 16'h0, 1'b1); step();
    check_rd("x7_after", 5'd7, 5'd9, 1'b0, 32'h0, 16'h0, 1'b1); step();
    step();

    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL done_missing: got %0d pending want 0", done_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL read_pending: got %0d pending want 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_slc.md
REGFILE_SLC -- requirements
Module: regfile_slc

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register width in bits.
REQ-002 SHALL have parameter SLICE_W, default 16, meaning bits written per cycle; legal values are 8, 16 and 32; NSLICE = XLEN/SLICE_W.
REQ-003 SHALL have parameter NREG, default 32, meaning register count; index width is 5.
REQ-004 SHALL have ports clk (in, 1, clock) and rst (in, 1, reset); one clock, reset asynchronous and active-high.
REQ-005 SHALL have ports wr_valid_i (in, 1, write request) and wr_ready_o (out, 1, sequencer idle).
REQ-006 SHALL have ports wr_rd_i (in, 5, destination), wr_size_i (in, cs_size, SIZE_W/SIZE_H/SIZE_B) and wr_ext_i (in, cs_ext, EXT_Z/EXT_S).
REQ-007 SHALL have ports sdata_valid_i (in, 1, slice data present) and sdata_i (in, SLICE_W, slice data, LSB slice first).
REQ-008 SHALL have ports wr_busy_o (out, 1, transaction active) and wr_done_o (out, 1, one-cycle pulse after the last slice is written).
REQ-009 SHALL have ports rs1_i and rs2_i (in, 5 each), rs2_slice_i (in, max(1,$clog2(NSLICE)), slice select), rs1_do (out, XLEN, full register) and rs2_do (out, SLICE_W, selected slice).

Function
REQ-010 Reads SHALL be combinational; x0 SHALL always read 0.
REQ-011 The FSM SHALL have states IDLE, DATA and EXT; wr_ready_o = (state==IDLE) and wr_busy_o = !wr_ready_o.
REQ-012 In IDLE, wr_valid_i SHALL latch rd, size and ext, clear slice counter cnt, and move to DATA next cycle.
REQ-013 Data slice count ND SHALL be 1 for SIZE_B, ceil(16/SLICE_W) for SIZE_H, and NSLICE for SIZE_W.
REQ-014 In DATA, each cycle with sdata_valid_i high SHALL write sdata_i to slice cnt of rd and increment cnt; a cycle with sdata_valid_i low SHALL stall with no write.
REQ-015 In the last data slice, bits above the size width (bit 8 for B, bit 16 for H) SHALL be replaced by the extension value.
REQ-016 The extension value SHALL be all zeros for EXT_Z, or the replicated size MSB (bit 7 for B, bit 15 for H) for EXT_S, latched when written.
REQ-017 After the last data slice, if cnt<NSLICE the FSM SHALL go to EXT, else to IDLE.
REQ-018 EXT SHALL write the extension value to one slice per cycle with no input required, then return to IDLE after slice NSLICE-1.
REQ-019 wr_done_o SHALL pulse high for exactly the cycle in which the final slice write (data or EXT) occurs.
REQ-020 With rd=0, the sequence timing SHALL be identical but no storage SHALL change.
REQ-021 wr_valid_i while busy SHALL be ignored; sdata_valid_i in IDLE or EXT SHALL be ignored.
REQ-022 Without bypass, a written slice SHALL be visible on the read ports from the next cycle.

Reset
REQ-023 rst SHALL asynchronously clear all registers to 0, force IDLE, clear cnt and latched fields, and drive wr_ready_o=1, wr_busy_o=0 and wr_done_o=0.
REQ-024 Reset asserted mid-transaction SHALL abort the transaction with no partial completion and no wr_done_o pulse.

Configuration
REQ-025 With REGFILE_BYPASS_EN defined, when rs1_i/rs2_i match the active nonzero rd and the slice being written this cycle, the read ports SHALL return the value being written in that cycle.
REQ-026 Without REGFILE_BYPASS_EN, reads SHALL return stored contents only.

Structure
REQ-027 cs_size, cs_ext and the FSM state enum SHALL live in the shared typedefs package.
REQ-028 The FSM, cnt and the extension logic SHALL be a sub-module regfile_wseq, and storage plus read muxing SHALL remain in regfile_slc.

Verification (defaults)
REQ-029 Reset -> rs1_do=0 for all indices, wr_ready_o=1, wr_done_o=0.
REQ-030 SIZE_W to x5 with slices 0x1234 then 0xABCD -> rs1_do(x5)=0xABCD1234, wr_done_o on the 2nd DATA cycle.
REQ-031 SIZE_B with EXT_S and slice 0x0080 to x7 -> 1 DATA cycle plus 1 EXT cycle; x7=0xFFFFFF80.
REQ-032 SIZE_H with EXT_Z and slice 0x8001 to x9, with sdata_valid_i low for 2 cycles first -> stall honoured; x9=0x00008001.
REQ-033 SIZE_W to x0 -> same cycle count as the x5 case and wr_done_o pulses; x0 reads 0.
REQ-034 rst asserted after the first slice of a SIZE_W write to x3 -> x3=0, IDLE, no wr_done_o.
